mem_bus_arbiter: RTL

Shares the single-port program/data memory between the CPU (fetch and execute machine cycles) and the debug/loader port. It runs every access through wait states and returns a one-cycle completion pulse. `cpu_done` is the `done` input of the CPU timing generator, so this block sets the pace of every T-beat. It sits between the timing generator/datapath and the memory.

---
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port memory between the CPU and the debug/loader port.
// Every access holds mem_en for WAIT_CYC+1 cycles, then pulses done/ack once.
module mem_bus_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned WAIT_CYC = 1   // 0..3; must be >=1 for synchronous-read RAM
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    input  logic          dbg_lock,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          gnt_dbg,
    output logic          busy
);
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          owner_dbg_q, owner_dbg_d;
    logic          last_dbg_q, last_dbg_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          cpu_elig, dbg_elig, pick_dbg;

    always_comb begin
        state_d     = state_q;
        owner_dbg_d = owner_dbg_q;
        last_dbg_d  = last_dbg_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        cpu_elig = cpu_req & ~dbg_lock;
        dbg_elig = dbg_req;
        // On a tie the port served last loses.
        pick_dbg = dbg_elig & (~cpu_elig | ~last_dbg_q);

        case (state_q)
            ST_IDLE: begin
                if (cpu_elig | dbg_elig) begin
                    state_d     = ST_ACCESS;
                    owner_dbg_d = pick_dbg;
                    we_d        = pick_dbg ? dbg_we    : cpu_we;
                    addr_d      = pick_dbg ? dbg_addr  : cpu_addr;
                    wdata_d     = pick_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d       = CW'(WAIT_CYC);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (owner_dbg_q) dbg_rdata_d = mem_rdata;
                        else             cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                last_dbg_d = owner_dbg_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_dbg_q <= 1'b0;
            last_dbg_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_dbg_q <= owner_dbg_d;
            last_dbg_q  <= last_dbg_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Strobes decode from state only, so no request input reaches an output.
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_done  = (state_q == ST_RESP) & ~owner_dbg_q;
    assign dbg_ack   = (state_q == ST_RESP) &  owner_dbg_q;
    assign gnt_dbg   = (state_q != ST_IDLE) &  owner_dbg_q;
    assign busy      = (state_q != ST_IDLE);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule
